// File: rtl/mux8_serializer_pkg.sv
// Shared types and constants for the mux8_serializer block.
// Optional feature macro: MUX8_SERIALIZER_PARITY_EN (adds an even-parity bit per word).
package mux8_serializer_pkg;

  localparam int WORD_W = 8;
  localparam int SEL_W  = 3;

  // Select value of the final data bit of a word (LSB-first).
  localparam logic [SEL_W-1:0] LAST_IDX = 3'd7;

  // PARITY is only reachable when MUX8_SERIALIZER_PARITY_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } state_e;

endpackage

// File: rtl/mux_8to1.sv
// Plain 8-to-1 bit multiplexer used to pick the current serial bit.
module mux_8to1 (
  input  logic [7:0] data_i,
  input  logic [2:0] sel_i,
  output logic       y_o
);

  // Select one of eight data bits.
  always_comb begin
    y_o = data_i[sel_i];
  end

endmodule

// File: rtl/mux8_serializer.sv
// LSB-first word serialiser with valid/ready on both sides, built around mux_8to1.
// Optional feature macro: MUX8_SERIALIZER_PARITY_EN appends an even-parity bit
// after bit 7 and moves ser_last onto it.
module mux8_serializer
  import mux8_serializer_pkg::*;
#(
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_bit,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic              busy
);

  localparam bit        HAS_GAP  = (GAP_CYCLES > 0);
  // Terminal value of the gap counter; irrelevant when HAS_GAP is 0.
  localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [SEL_W-1:0]   bitcnt_q, bitcnt_d;
  logic [3:0]         gapcnt_q, gapcnt_d;
`ifdef MUX8_SERIALIZER_PARITY_EN
  logic               par_q, par_d;
`endif

  logic               in_ready_raw;
  logic               load;
  logic               mux_y;

  // Holding register feeds the mux data inputs; bit counter drives the select.
  mux_8to1 u_mux (
    .data_i (word_q),
    .sel_i  (bitcnt_q),
    .y_o    (mux_y)
  );

`ifdef MUX8_SERIALIZER_PARITY_EN
  // Serial bit comes from the mux, or from the stored parity in the PARITY state.
  always_comb begin
    ser_bit = (state_q == PARITY) ? par_q : mux_y;
  end
`else
  // Serial bit is the mux output, driven purely from registered state.
  always_comb begin
    ser_bit = mux_y;
  end
`endif

  // Next-state, counters and handshake outputs.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    bitcnt_d     = bitcnt_q;
    gapcnt_d     = gapcnt_q;
`ifdef MUX8_SERIALIZER_PARITY_EN
    par_d        = par_q;
`endif
    in_ready_raw = 1'b0;
    ser_valid    = 1'b0;
    ser_last     = 1'b0;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_raw = 1'b1;
      end

      SHIFT: begin
        ser_valid = 1'b1;
`ifdef MUX8_SERIALIZER_PARITY_EN
        if (ser_ready) begin
          if (bitcnt_q == LAST_IDX) state_d = PARITY;
          else                      bitcnt_d = bitcnt_q + 3'd1;
        end
`else
        ser_last = (bitcnt_q == LAST_IDX);
        if (bitcnt_q == LAST_IDX) begin
          // Final beat: with no gap a new word may be taken in the same cycle.
          in_ready_raw = !HAS_GAP && ser_ready;
          if (ser_ready) begin
            state_d  = HAS_GAP ? GAP : IDLE;
            gapcnt_d = 4'd0;
          end
        end else if (ser_ready) begin
          bitcnt_d = bitcnt_q + 3'd1;
        end
`endif
      end

`ifdef MUX8_SERIALIZER_PARITY_EN
      PARITY: begin
        ser_valid    = 1'b1;
        ser_last     = 1'b1;
        in_ready_raw = !HAS_GAP && ser_ready;
        if (ser_ready) begin
          state_d  = HAS_GAP ? GAP : IDLE;
          gapcnt_d = 4'd0;
        end
      end
`endif

      GAP: begin
        if (gapcnt_q == GAP_LAST) begin
          state_d  = IDLE;
          gapcnt_d = 4'd0;
        end else begin
          gapcnt_d = gapcnt_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // An accepted word always restarts shifting from bit 0, overriding the above.
    load = in_valid && in_ready_raw && !rst;
    if (load) begin
      state_d  = SHIFT;
      word_d   = in_data;
      bitcnt_d = '0;
`ifdef MUX8_SERIALIZER_PARITY_EN
      par_d    = ^in_data;
`endif
    end
  end

  // Handshake and status outputs, forced inactive while reset is held.
  always_comb begin
    in_ready = in_ready_raw && !rst;
    busy     = (state_q != IDLE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
`ifdef MUX8_SERIALIZER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
`ifdef MUX8_SERIALIZER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux8_serializer.sv
// Directed self-checking bench for mux8_serializer (GAP_CYCLES=0 and GAP_CYCLES=3 instances).
// Honours MUX8_SERIALIZER_PARITY_EN: words then carry 9 bits with ser_last on the parity bit.
module tb_mux8_serializer;

`ifdef MUX8_SERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       ser_ready;

  logic a_in_ready, a_ser_bit, a_ser_valid, a_ser_last, a_busy;
  logic b_in_ready, b_ser_bit, b_ser_valid, b_ser_last, b_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux8_serializer #(.GAP_CYCLES(0)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .ser_bit   (a_ser_bit),
    .ser_valid (a_ser_valid),
    .ser_ready (ser_ready),
    .ser_last  (a_ser_last),
    .busy      (a_busy)
  );

  mux8_serializer #(.GAP_CYCLES(3)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .ser_bit   (b_ser_bit),
    .ser_valid (b_ser_valid),
    .ser_ready (ser_ready),
    .ser_last  (b_ser_last),
    .busy      (b_busy)
  );

  // Expected serial bit i of word w (index 8 is the even-parity bit).
  function automatic logic exp_bit(input logic [7:0] w, input int i);
    if (i < 8) return w[i];
    return ^w;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  // Load a word into dut_a with ser_ready held high and check every bit.
  task automatic send_word(input logic [7:0] w, input string tag);
    in_data   = w;
    in_valid  = 1'b1;
    ser_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, a_in_ready, 1);
    chk({tag, "_busy0"}, a_busy, 0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      #1;
      chk($sformatf("%s_valid%0d", tag, i), a_ser_valid, 1);
      chk($sformatf("%s_bit%0d", tag, i), a_ser_bit, exp_bit(w, i));
      chk($sformatf("%s_last%0d", tag, i), a_ser_last, (i == NB - 1) ? 1 : 0);
      chk($sformatf("%s_busy%0d", tag, i), a_busy, 1);
      $display("%s: bit %0d ser_bit=%0d ser_last=%0d", tag, i, a_ser_bit, a_ser_last);
      step();
    end
    #1;
    chk({tag, "_done_valid"}, a_ser_valid, 0);
    chk({tag, "_done_busy"}, a_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    int k;
    int c;

    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b1;
    ser_ready = 1'b1;

    // Reset values while rst is held (in_valid high must not matter).
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_ser_valid", a_ser_valid, 0);
    chk("rst_ser_last", a_ser_last, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ser_bit", a_ser_bit, 0);
    chk("rst_b_in_ready", b_in_ready, 0);
    $display("reset: in_ready=%0d ser_valid=%0d busy=%0d", a_in_ready, a_ser_valid, a_busy);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;

    // Test 1: 8'hA5 with ser_ready held high.
    send_word(8'hA5, "t1_A5");

    // Test 2: 8'h3C with ser_ready pattern 1,0,0,1 repeating.
    pat      = 4'b1001;
    in_data  = 8'h3C;
    in_valid = 1'b1;
    ser_ready = 1'b0;
    step();
    in_valid = 1'b0;
    k = 0;
    c = 0;
    while (k < NB && c < 40) begin
      ser_ready = pat[c % 4];
      #1;
      chk($sformatf("t2_valid_c%0d", c), a_ser_valid, 1);
      chk($sformatf("t2_bit_c%0d", c), a_ser_bit, exp_bit(8'h3C, k));
      chk($sformatf("t2_last_c%0d", c), a_ser_last, (k == NB - 1) ? 1 : 0);
      $display("t2: cycle %0d ready=%0d bit %0d ser_bit=%0d", c, ser_ready, k, a_ser_bit);
      if (ser_ready) k++;
      c++;
      step();
    end
    chk("t2_all_bits_sent", k, NB);
    #1;
    chk("t2_done_valid", a_ser_valid, 0);

    // Test 3: back-to-back 8'hFF then 8'h00 on the zero-gap instance.
    pulse_reset();
    in_data   = 8'hFF;
    in_valid  = 1'b1;
    ser_ready = 1'b1;
    #1;
    chk("t3_in_ready_c0", a_in_ready, 1);
    step();
    in_data = 8'h00;
    for (int cy = 1; cy <= 2 * NB; cy++) begin
      if (cy == 2 * NB) in_valid = 1'b0;
      #1;
      chk($sformatf("t3_valid_c%0d", cy), a_ser_valid, 1);
      chk($sformatf("t3_bit_c%0d", cy), a_ser_bit,
          (cy <= NB) ? exp_bit(8'hFF, cy - 1) : exp_bit(8'h00, cy - NB - 1));
      chk($sformatf("t3_in_ready_c%0d", cy), a_in_ready, (cy == NB || cy == 2 * NB) ? 1 : 0);
      chk($sformatf("t3_last_c%0d", cy), a_ser_last, (cy == NB || cy == 2 * NB) ? 1 : 0);
      $display("t3: cycle %0d ser_bit=%0d in_ready=%0d", cy, a_ser_bit, a_in_ready);
      step();
    end
    #1;
    chk("t3_done_valid", a_ser_valid, 0);

    // Test 4: GAP_CYCLES=3 instance, second word offered during the gap.
    pulse_reset();
    in_data   = 8'h5A;
    in_valid  = 1'b1;
    ser_ready = 1'b1;
    #1;
    chk("t4_in_ready_c0", b_in_ready, 1);
    step();
    in_data = 8'hC3;
    for (int cy = 1; cy <= 2 * NB + 4; cy++) begin
      if (cy == 2 * NB + 4) in_valid = 1'b0;
      #1;
      if (cy <= NB) begin
        chk($sformatf("t4_valid_c%0d", cy), b_ser_valid, 1);
        chk($sformatf("t4_bit_c%0d", cy), b_ser_bit, exp_bit(8'h5A, cy - 1));
        chk($sformatf("t4_last_c%0d", cy), b_ser_last, (cy == NB) ? 1 : 0);
        chk($sformatf("t4_in_ready_c%0d", cy), b_in_ready, 0);
      end else if (cy <= NB + 3) begin
        chk($sformatf("t4_gap_valid_c%0d", cy), b_ser_valid, 0);
        chk($sformatf("t4_gap_in_ready_c%0d", cy), b_in_ready, 0);
        chk($sformatf("t4_gap_busy_c%0d", cy), b_busy, 1);
      end else if (cy == NB + 4) begin
        chk("t4_idle_valid", b_ser_valid, 0);
        chk("t4_idle_in_ready", b_in_ready, 1);
        chk("t4_idle_busy", b_busy, 0);
      end else begin
        chk($sformatf("t4_w2_valid_c%0d", cy), b_ser_valid, 1);
        chk($sformatf("t4_w2_bit_c%0d", cy), b_ser_bit, exp_bit(8'hC3, cy - NB - 5));
        chk($sformatf("t4_w2_in_ready_c%0d", cy), b_in_ready, 0);
      end
      $display("t4: cycle %0d ser_valid=%0d ser_bit=%0d in_ready=%0d", cy, b_ser_valid, b_ser_bit, b_in_ready);
      step();
    end

    // Test 5: reset after bit 4 of 8'hF0, then 8'h01 from bit 0.
    pulse_reset();
    in_data   = 8'hF0;
    in_valid  = 1'b1;
    ser_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t5_bit%0d", i), a_ser_bit, exp_bit(8'hF0, i));
      step();
    end
    rst = 1'b1;
    #1;
    chk("t5_rst_ser_valid", a_ser_valid, 0);
    chk("t5_rst_ser_bit", a_ser_bit, 0);
    chk("t5_rst_busy", a_busy, 0);
    chk("t5_rst_in_ready", a_in_ready, 0);
    chk("t5_rst_ser_last", a_ser_last, 0);
    $display("t5: mid-word reset ser_valid=%0d ser_bit=%0d", a_ser_valid, a_ser_bit);
    rst = 1'b0;
    #1;
    send_word(8'h01, "t5_01");

    // Test 6: 8'h07 (parity bit 1 when the parity feature is built in).
    send_word(8'h07, "t6_07");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
